ahb_s2m_mux: RTL
================

// Module: ahb_s2m_mux
// PURPOSE
// - Slave-to-master response multiplexer that sits directly downstream of the AHB address decoder.
// - Registers the decoder's HSELx outputs into a data-phase select.
// - Steers the selected slave's HRDATA/HREADY/HRESP back to the master; its HREADY output is the system HREADY.
// - Adds a bus-hang watchdog: a stall longer than TIMEOUT_CYCLES is terminated with a two-cycle ERROR.
// PARAMETERS
// - DATA_W         32   read data width
// - TIMEOUT_CYCLES 256  max consecutive wait states before forced ERROR; 0 disables the watchdog
// - CNT_W          9    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
// - HCLK           in   1       system bus clock
// - HRESETn        in   1       reset, synchronous, active-low
// - HTRANS         in   2       address-phase transfer type
// - HSELAHBAPB     in   1       decoder select: APB bridge
// - HSELSSRAM      in   1       decoder select: SSRAM controller
// - HSELMYIP       in   1       decoder select: MYIP
// - HSELDefault    in   1       decoder select: default slave
// - HRDATAAPB/HRDATASSRAM/HRDATAMYIP  in  DATA_W  slave read data
// - HREADYAPB/HREADYSSRAM/HREADYMYIP/HREADYDefault  in  1  slave ready
// - HRESPAPB/HRESPSSRAM/HRESPMYIP/HRESPDefault      in  2  slave response
// - HRDATA         out  DATA_W  muxed read data to master
// - HREADY         out  1       system HREADY (also fed back to slaves as HREADYIn)
// - HRESP          out  2       muxed response to master
// - TIMEOUTIRQ     out  1       sticky watchdog flag
// - TIMEOUTCLR     in   1       clears TIMEOUTIRQ (single-cycle pulse)
// BEHAVIOUR
// Reset values (HRESETn low at a rising HCLK edge; synchronous, sampled at the edge)
// - DSel=NONE, DValid=0, state=NORM, count=0, TIMEOUTIRQ=0.
// - Outputs: HREADY=1, HRESP=OKAY, HRDATA=0.
// Address-phase priority encode
// - Priority MYIP > SSRAM > APB > Default; no select asserted => NONE.
// - MYIP must win: the decoder asserts HSELMYIP and HSELDefault together for 0xC21xxxxx.
// Data-phase select register
// - On a rising edge with HREADY=1: DSel <= encode; DValid <= (encode!=NONE) & HTRANS[1].
// - HREADY=0 holds both.
// Combinational mux in state NORM
// - HRDATA/HREADY/HRESP = DSel slave's signals.
// - Default slave contributes HRDATA=0.
// - NONE: HREADY=1, HRESP=OKAY, HRDATA=0.
// Watchdog (TIMEOUT_CYCLES>0)
// - count increments on each cycle where state=NORM & DValid & the selected slave's HREADY=0.
// - Otherwise count clears to 0, saturating at TIMEOUT_CYCLES.
// FSM
// - NORM -> ERR1 when count==TIMEOUT_CYCLES and the slave is still not ready.
// - ERR1: HREADY=0, HRESP=ERROR, HRDATA=0; TIMEOUTIRQ <= 1; -> ERR2 unconditionally.
// - ERR2: HREADY=1, HRESP=ERROR; DSel/DValid load from the current address phase; count <= 0; -> NORM.
// - A slave that goes ready during ERR1/ERR2 is ignored; ERROR is reported regardless.
// Simultaneous events and boundaries
// - TIMEOUTCLR and a new timeout in the same cycle: set wins.
// - Slave ready in the same cycle count reaches the limit: the transfer completes normally with no ERROR.
// - Reset mid-ERR1/ERR2 returns to NORM with reset values on the next edge.
// - Zero-wait transfers never increment count.
// STRUCTURE
// - Package ahb_pkg: HTRANS/HRESP encodings (IDLE/BUSY/NONSEQ/SEQ, OKAY/ERROR/RETRY/SPLIT).
// - Package ahb_pkg also holds the DSel codes: NONE=0, APB=1, SSRAM=2, MYIP=3, DEF=4 (3-bit).
// - Package ahb_pkg also holds the FSM encoding: NORM/ERR1/ERR2.
// - Sub-module ahb_watchdog: counter + FSM + sticky IRQ.
// - The top level holds the priority encoder, select register and output mux.
// TESTING
// 1. Reset: HRESETn=0 for 2 cycles -> HREADY=1, HRESP=00, HRDATA=0, TIMEOUTIRQ=0.
// 2. SSRAM read: HSELSSRAM=1, HTRANS=10; next cycle HRDATASSRAM=0xA5A5_1234, HREADYSSRAM=1 -> HRDATA=0xA5A5_1234, HREADY=1.
// 3. Overlap: HSELMYIP=1 and HSELDefault=1 with NONSEQ -> data phase follows the MYIP signals; HRESP=00, not ERROR.
// 4. Wait states: APB holds HREADYAPB=0 for 3 cycles with TIMEOUT_CYCLES=4 -> HREADY low 3 cycles, then the normal OKAY; TIMEOUTIRQ=0.
// 5. Timeout: TIMEOUT_CYCLES=4, HREADYAPB stuck 0 -> after 4 stalled cycles: one cycle HREADY=0/HRESP=01, one cycle HREADY=1/HRESP=01; TIMEOUTIRQ=1 until TIMEOUTCLR pulse.
// 6. Reset mid-error: assert HRESETn=0 during ERR1 -> next edge HREADY=1, HRESP=00, TIMEOUTIRQ=0, state NORM.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings for the slave-to-master response path:
// transfer types, responses, data-phase select codes and watchdog FSM states.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef logic [2:0] dsel_t;

  localparam dsel_t DSEL_NONE  = 3'd0;
  localparam dsel_t DSEL_APB   = 3'd1;
  localparam dsel_t DSEL_SSRAM = 3'd2;
  localparam dsel_t DSEL_MYIP  = 3'd3;
  localparam dsel_t DSEL_DEF   = 3'd4;

  localparam logic [1:0] ST_NORM = 2'd0;
  localparam logic [1:0] ST_ERR1 = 2'd1;
  localparam logic [1:0] ST_ERR2 = 2'd2;

  // MYIP must beat Default: the decoder raises both for the MYIP window.
  function automatic dsel_t dsel_encode(input logic myip, input logic ssram,
                                        input logic apb, input logic def);
    dsel_t enc;
    if (myip)       enc = DSEL_MYIP;
    else if (ssram) enc = DSEL_SSRAM;
    else if (apb)   enc = DSEL_APB;
    else if (def)   enc = DSEL_DEF;
    else            enc = DSEL_NONE;
    return enc;
  endfunction

  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_watchdog.sv
// Bus-hang watchdog: counts consecutive wait states of a valid data phase and
// forces a two-cycle ERROR once the stall exceeds TIMEOUT_CYCLES.
module ahb_watchdog
  import ahb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       dvalid,
  input  logic       slave_ready,
  input  logic       TIMEOUTCLR,
  output logic [1:0] state,
  output logic       TIMEOUTIRQ
);

  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               ENABLE = (TIMEOUT_CYCLES > 0);

  logic [CNT_W-1:0] count;
  logic             stall;
  logic             expire;

  always_comb begin
    stall  = ENABLE && (state == ST_NORM) && dvalid && !slave_ready;
    expire = stall && (count == LIMIT);
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= ST_NORM;
      count <= '0;
    end else begin
      case (state)
        ST_NORM: begin
          if (expire) state <= ST_ERR1;
          if (!stall)               count <= '0;
          else if (count != LIMIT)  count <= count + 1'b1;
        end
        ST_ERR1: begin
          state <= ST_ERR2;
          count <= '0;
        end
        ST_ERR2: begin
          state <= ST_NORM;
          count <= '0;
        end
        default: begin
          state <= ST_NORM;
          count <= '0;
        end
      endcase
    end
  end

  // A timeout being raised beats a simultaneous clear request.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)              TIMEOUTIRQ <= 1'b0;
    else if (state == ST_ERR1) TIMEOUTIRQ <= 1'b1;
    else if (TIMEOUTCLR)       TIMEOUTIRQ <= 1'b0;
  end

endmodule

// File: rtl/ahb_s2m_mux.sv
// Slave-to-master response multiplexer: registers the decoder selects into a
// data-phase select, steers the chosen slave's response and drives system HREADY.
module ahb_s2m_mux
  import ahb_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 9
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [1:0]        HTRANS,
  input  logic              HSELAHBAPB,
  input  logic              HSELSSRAM,
  input  logic              HSELMYIP,
  input  logic              HSELDefault,
  input  logic [DATA_W-1:0] HRDATAAPB,
  input  logic [DATA_W-1:0] HRDATASSRAM,
  input  logic [DATA_W-1:0] HRDATAMYIP,
  input  logic              HREADYAPB,
  input  logic              HREADYSSRAM,
  input  logic              HREADYMYIP,
  input  logic              HREADYDefault,
  input  logic [1:0]        HRESPAPB,
  input  logic [1:0]        HRESPSSRAM,
  input  logic [1:0]        HRESPMYIP,
  input  logic [1:0]        HRESPDefault,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic [1:0]        HRESP,
  output logic              TIMEOUTIRQ,
  input  logic              TIMEOUTCLR
);

  dsel_t             enc;
  dsel_t             dsel;
  logic              dvalid;
  logic [1:0]        wd_state;
  logic              sel_ready;
  logic [1:0]        sel_resp;
  logic [DATA_W-1:0] sel_data;

  always_comb enc = dsel_encode(HSELMYIP, HSELSSRAM, HSELAHBAPB, HSELDefault);

  // HREADY is the system ready, so ERR2 (HREADY=1) loads the next address phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dsel   <= DSEL_NONE;
      dvalid <= 1'b0;
    end else if (HREADY) begin
      dsel   <= enc;
      dvalid <= (enc != DSEL_NONE) && htrans_active(HTRANS);
    end
  end

  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = HRESP_OKAY;
    sel_data  = '0;
    case (dsel)
      DSEL_APB: begin
        sel_ready = HREADYAPB;
        sel_resp  = HRESPAPB;
        sel_data  = HRDATAAPB;
      end
      DSEL_SSRAM: begin
        sel_ready = HREADYSSRAM;
        sel_resp  = HRESPSSRAM;
        sel_data  = HRDATASSRAM;
      end
      DSEL_MYIP: begin
        sel_ready = HREADYMYIP;
        sel_resp  = HRESPMYIP;
        sel_data  = HRDATAMYIP;
      end
      DSEL_DEF: begin
        sel_ready = HREADYDefault;
        sel_resp  = HRESPDefault;
      end
      default: ;
    endcase
  end

  always_comb begin
    HREADY = sel_ready;
    HRESP  = sel_resp;
    HRDATA = sel_data;
    case (wd_state)
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
        HRDATA = '0;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = HRESP_ERROR;
        HRDATA = '0;
      end
      default: ;
    endcase
  end

  ahb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .dvalid      (dvalid),
    .slave_ready (sel_ready),
    .TIMEOUTCLR  (TIMEOUTCLR),
    .state       (wd_state),
    .TIMEOUTIRQ  (TIMEOUTIRQ)
  );

endmodule
